// File: rtl/cpu_defs.sv
// -----------------------------------------------------------------------------
// cpu_defs
// Shared definitions for the 5-stage core's memory controller.
//   ST_*     : memory controller FSM state encoding (2 bits)
//   STALL_*  : per-source stall masks, bit i stalls stage register i
//              ([0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB)
// -----------------------------------------------------------------------------
package cpu_defs;

    typedef logic [5:0] stall_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_IF   = 2'd1;
    localparam logic [1:0] ST_MEM  = 2'd2;

    localparam stall_t STALL_MEM  = 6'b011111;
    localparam stall_t STALL_EX   = 6'b001111;
    localparam stall_t STALL_ID   = 6'b000111;
    localparam stall_t STALL_IF   = 6'b000011;
    localparam stall_t STALL_NONE = 6'b000000;

    localparam logic [3:0] SEL_WORD = 4'hF;

endpackage

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if
// Shared memory bus between the controller (master) and the memory (slave).
//   bus_req/bus_we/bus_addr/bus_wdata/bus_sel : registered command, master out
//   bus_ack   : completion, sampled by the master on the rising clock edge
//   bus_rdata : read data, valid together with bus_ack
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [3:0]        bus_sel;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_sel,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_ctrl_stall_gen.sv
// -----------------------------------------------------------------------------
// stall_gen
// Combinational stall vector: bitwise OR of the masks of every active source.
//   mem_req/mem_valid : pending load/store (masked off while its pulse is high)
//   if_req/if_valid   : pending fetch (masked off while its pulse is high)
//   stallreq_id/ex    : hazard / multi-cycle stall requests
//   stall             : 6-bit stage stall vector, bit 5 never set
// -----------------------------------------------------------------------------
module stall_gen
    import cpu_defs::*;
(
    input  logic   mem_req,
    input  logic   mem_valid,
    input  logic   if_req,
    input  logic   if_valid,
    input  logic   stallreq_id,
    input  logic   stallreq_ex,
    output stall_t stall
);

    always_comb begin
        stall = STALL_NONE;
        if (mem_req && !mem_valid) stall = stall | STALL_MEM;
        if (stallreq_ex)           stall = stall | STALL_EX;
        if (stallreq_id)           stall = stall | STALL_ID;
        if (if_req && !if_valid)   stall = stall | STALL_IF;
    end

endmodule

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl
// Arbitrates the single memory bus between instruction fetch and load/store,
// and produces the pipeline stall vector.
//   clk, rst        : clock, asynchronous active-high reset
//   if_*            : fetch request/address in, instruction + 1-cycle valid out
//   mem_*           : load/store request in, load data + 1-cycle valid out
//   stallreq_id/ex  : stage stall requests merged into stall
//   bus             : memory bus (master side), registered command
//   stall           : stage stalls [0] PC .. [5] WB
// Load/store wins simultaneous requests. Each transaction passes through IDLE
// for at least one cycle, so a completing request (whose valid is high) is
// never relaunched by the guard below.
// -----------------------------------------------------------------------------
module mem_ctrl
    import cpu_defs::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,

    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [3:0]        mem_sel,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_valid,

    input  logic              stallreq_id,
    input  logic              stallreq_ex,

    mem_ctrl_if.master        bus,

    output stall_t            stall
);

    logic [1:0]        state_q,     state_d;
    logic              bus_req_q,   bus_req_d;
    logic              bus_we_q,    bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]        bus_sel_q,   bus_sel_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic              if_valid_q,  if_valid_d;
    logic              mem_valid_q, mem_valid_d;

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_sel_d   = bus_sel_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        // valids are single-cycle pulses
        if_valid_d  = 1'b0;
        mem_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_req && !mem_valid_q) begin
                    state_d     = ST_MEM;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    bus_sel_d   = mem_sel;
                end else if (if_req && !if_valid_q) begin
                    state_d     = ST_IF;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_sel_d   = SEL_WORD;
                end
            end
            ST_IF: begin
                if (bus.bus_ack) begin
                    state_d    = ST_IDLE;
                    bus_req_d  = 1'b0;
                    if_rdata_d = bus.bus_rdata;
                    if_valid_d = 1'b1;
                end
            end
            ST_MEM: begin
                // captured on stores too; the value is meaningless there
                if (bus.bus_ack) begin
                    state_d     = ST_IDLE;
                    bus_req_d   = 1'b0;
                    mem_rdata_d = bus.bus_rdata;
                    mem_valid_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_sel_q   <= 4'h0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_valid_q  <= 1'b0;
            mem_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_sel_q   <= bus_sel_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_valid_q  <= if_valid_d;
            mem_valid_q <= mem_valid_d;
        end
    end

    assign bus.bus_req   = bus_req_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign bus.bus_sel   = bus_sel_q;

    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign mem_rdata = mem_rdata_q;
    assign mem_valid = mem_valid_q;

    stall_gen u_stall_gen (
        .mem_req     (mem_req),
        .mem_valid   (mem_valid_q),
        .if_req      (if_req),
        .if_valid    (if_valid_q),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .stall       (stall)
    );

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl: stall vector table, bus slave responder
// with programmable wait states, scoreboard of expected bus commands, and
// hand-written sequences for reset, latency, arbitration and relaunch cases.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } cmd_t;

    typedef struct {
        logic       mem_req;
        logic       if_req;
        logic       id;
        logic       ex;
        logic [5:0] stall;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, stallreq_id, stallreq_ex;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic [31:0] if_rdata, mem_rdata;
    logic        if_valid, mem_valid;
    logic [5:0]  stall;

    // responder controls (written by the main sequence only)
    logic        resp_en   = 1'b0;
    logic        force_ack = 1'b0;
    int          bus_wait  = 0;
    logic [31:0] resp_data = 32'h0;

    // responder state and log (written by the responder only)
    int   wcnt    = 0;
    int   obs_cnt = 0;
    cmd_t obs_log [0:63];

    int if_vcyc  = 0;
    int mem_vcyc = 0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   rd    = 0;
    cmd_t exp_q [$];
    vec_t vecs  [9];

    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bif ();

    mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_sel     (mem_sel),
        .mem_rdata   (mem_rdata),
        .mem_valid   (mem_valid),
        .stallreq_id (stallreq_id),
        .stallreq_ex (stallreq_ex),
        .bus         (bif.master),
        .stall       (stall)
    );

    // Bus slave: acks after bus_wait idle cycles, logs the command it acked.
    always @(negedge clk) begin
        if (force_ack) begin
            bif.bus_ack = 1'b1;
        end else if (resp_en && bif.bus_req && !bif.bus_ack) begin
            if (wcnt >= bus_wait) begin
                bif.bus_ack   = 1'b1;
                bif.bus_rdata = resp_data;
                wcnt          = 0;
                if (obs_cnt < 64) begin
                    obs_log[obs_cnt].we    = bif.bus_we;
                    obs_log[obs_cnt].addr  = bif.bus_addr;
                    obs_log[obs_cnt].wdata = bif.bus_wdata;
                    obs_log[obs_cnt].sel   = bif.bus_sel;
                end
                obs_cnt++;
            end else begin
                wcnt++;
            end
        end else begin
            bif.bus_ack   = 1'b0;
            bif.bus_rdata = 32'h0;
        end
    end

    always @(negedge clk) begin
        if (if_valid)  if_vcyc++;
        if (mem_valid) mem_vcyc++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // compare every newly acked bus command against the expected queue
    task automatic drain();
        cmd_t e;
        while (rd < obs_cnt) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_txn", 64'(obs_log[rd].addr), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_bus_we",   64'(obs_log[rd].we),   64'(e.we));
                chk("sb_bus_addr", 64'(obs_log[rd].addr), 64'(e.addr));
                chk("sb_bus_sel",  64'(obs_log[rd].sel),  64'(e.sel));
                if (e.we) chk("sb_bus_wdata", 64'(obs_log[rd].wdata), 64'(e.wdata));
            end
            rd++;
        end
    endtask

    initial begin
        int  n, c, iv0, mv0, tx0;
        logic done, mdone, idone;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b000111};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b001111};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'b001111};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000011};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b000111};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b001111};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b011111};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};

        rst = 1'b1;
        if_req = 0; mem_req = 0; mem_we = 0; stallreq_id = 0; stallreq_ex = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_sel = 0;

        // ---- reset values
        repeat (3) @(negedge clk);
        chk("rst_bus_req",   64'(bif.bus_req),   64'h0);
        chk("rst_bus_we",    64'(bif.bus_we),    64'h0);
        chk("rst_bus_addr",  64'(bif.bus_addr),  64'h0);
        chk("rst_bus_wdata", 64'(bif.bus_wdata), 64'h0);
        chk("rst_bus_sel",   64'(bif.bus_sel),   64'h0);
        chk("rst_if_rdata",  64'(if_rdata),      64'h0);
        chk("rst_mem_rdata", 64'(mem_rdata),     64'h0);
        chk("rst_if_valid",  64'(if_valid),      64'h0);
        chk("rst_mem_valid", 64'(mem_valid),     64'h0);
        chk("rst_stall",     64'(stall),         64'h0);
        step();
        rst = 1'b0;

        // ---- stall mask table (bus never acks, so valids stay low)
        foreach (vecs[i]) begin
            step();
            mem_req = vecs[i].mem_req; if_req = vecs[i].if_req;
            stallreq_id = vecs[i].id;  stallreq_ex = vecs[i].ex;
            mem_addr = 32'h44; mem_sel = 4'h1; if_addr = 32'h8;
            @(negedge clk);
            chk($sformatf("stall_vec%0d", i), 64'(stall), 64'(vecs[i].stall));
        end

        // ---- reset mid-transaction
        chk("pre_rst_bus_req", 64'(bif.bus_req), 64'h1);
        iv0 = if_vcyc; mv0 = mem_vcyc;
        @(posedge clk);
        #3 rst = 1'b1;
        #1 chk("async_rst_bus_req", 64'(bif.bus_req), 64'h0);
        if_req = 0; mem_req = 0; stallreq_id = 0; stallreq_ex = 0;
        #1 chk("rst_stall_idle", 64'(stall), 64'h0);
        repeat (2) @(negedge clk);
        chk("rst_no_valid", 64'(if_vcyc - iv0 + mem_vcyc - mv0), 64'h0);
        step();
        rst = 1'b0;

        // ---- single fetch, 2 wait cycles
        resp_en = 1'b1; bus_wait = 2; resp_data = 32'h3C01_0001;
        exp_q.push_back('{1'b0, 32'h10, 32'h0, 4'hF});
        iv0 = if_vcyc;
        step();
        if_req = 1'b1; if_addr = 32'h10;
        n = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (if_valid) done = 1'b1;
            else begin
                chk("fetch_stall", 64'(stall), 64'b000011);
                if (k == 1) begin
                    chk("fetch_bus_req",  64'(bif.bus_req),  64'h1);
                    chk("fetch_bus_addr", 64'(bif.bus_addr), 64'h10);
                    chk("fetch_bus_we",   64'(bif.bus_we),   64'h0);
                end
                n++;
            end
        end
        chk("fetch_done", 64'(done), 64'h1);
        chk("fetch_latency", 64'(n), 64'h4);
        chk("fetch_rdata", 64'(if_rdata), 64'h3C01_0001);
        chk("fetch_stall_at_valid", 64'(stall), 64'h0);
        step();
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("fetch_bus_idle", 64'(bif.bus_req), 64'h0);
        chk("fetch_one_pulse", 64'(if_vcyc - iv0), 64'h1);
        chk("fetch_rdata_held", 64'(if_rdata), 64'h3C01_0001);
        drain();

        // ---- simultaneous store + fetch, zero-wait
        bus_wait = 0; resp_data = 32'h1357_9BDF;
        exp_q.push_back('{1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF});
        exp_q.push_back('{1'b0, 32'h40,  32'h0,         4'hF});
        iv0 = if_vcyc; mv0 = mem_vcyc;
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF; mem_sel = 4'hF;
        if_req = 1'b1; if_addr = 32'h40;
        mdone = 1'b0; idone = 1'b0; c = 0;
        for (int k = 0; k < 30 && !idone; k++) begin
            @(negedge clk);
            if (!mdone) begin
                chk("sim_order", 64'(if_valid), 64'h0);
                if (mem_valid) begin
                    mdone = 1'b1;
                    chk("sim_mem_latency", 64'(c), 64'h2);
                    chk("sim_idle_gap", 64'(bif.bus_req), 64'h0);
                    chk("sim_stall_after_mem", 64'(stall), 64'b000011);
                end else begin
                    chk("sim_stall_mem", 64'(stall), 64'b011111);
                end
            end else if (if_valid) begin
                idone = 1'b1;
            end else begin
                chk("sim_stall_if", 64'(stall), 64'b000011);
            end
            c++;
            step();
            if (mdone) mem_req = 1'b0;
            if (idone) if_req = 1'b0;
        end
        chk("sim_done", 64'({mdone, idone}), 64'h3);
        repeat (3) @(negedge clk);
        chk("sim_mem_pulses", 64'(mem_vcyc - mv0), 64'h1);
        chk("sim_if_pulses",  64'(if_vcyc - iv0),  64'h1);
        chk("sim_if_rdata",   64'(if_rdata),       64'h1357_9BDF);
        drain();

        // ---- load held through mem_valid: no relaunch
        bus_wait = 1; resp_data = 32'hCAFE_F00D;
        exp_q.push_back('{1'b0, 32'h200, 32'h0, 4'h3});
        mv0 = mem_vcyc; tx0 = obs_cnt;
        step();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_sel = 4'h3;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (mem_valid) done = 1'b1;
        end
        chk("load_done", 64'(done), 64'h1);
        step();
        mem_req = 1'b0;
        repeat (4) @(negedge clk);
        chk("load_one_txn",   64'(obs_cnt - tx0),   64'h1);
        chk("load_one_pulse", 64'(mem_vcyc - mv0),  64'h1);
        chk("load_rdata",     64'(mem_rdata),       64'hCAFE_F00D);
        drain();

        // ---- ack while idle is ignored
        iv0 = if_vcyc; mv0 = mem_vcyc; tx0 = obs_cnt;
        step();
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_ack_no_valid", 64'(if_vcyc - iv0 + mem_vcyc - mv0), 64'h0);
        chk("idle_ack_bus_req",  64'(bif.bus_req), 64'h0);
        chk("idle_ack_if_rdata", 64'(if_rdata),    64'h1357_9BDF);
        chk("idle_ack_mem_rdata", 64'(mem_rdata),  64'hCAFE_F00D);

        // controller still idle: a fresh fetch goes straight out
        bus_wait = 0; resp_data = 32'h0BAD_F00D;
        exp_q.push_back('{1'b0, 32'h80, 32'h0, 4'hF});
        step();
        if_req = 1'b1; if_addr = 32'h80;
        n = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (if_valid) done = 1'b1; else n++;
        end
        chk("post_idle_fetch_latency", 64'(n), 64'h2);
        chk("post_idle_fetch_rdata", 64'(if_rdata), 64'h0BAD_F00D);
        step();
        if_req = 1'b0;
        repeat (2) @(negedge clk);
        drain();
        chk("sb_pending", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Pipeline memory controller and stall generator for the 5-stage core. Arbitrates the single shared memory bus between instruction fetch (IF) and load/store (MEM), and produces the 6-bit `stall` vector consumed by `pc_reg` and the stage registers. It merges bus-wait stalls with the ID and EX stall requests.

## Interface
Parameters:
- `ADDR_W`, default 32: bus address width.
- `DATA_W`, default 32: bus data width.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `if_req`  in  1  fetch request for `if_addr`.
- `if_addr`  in  ADDR_W  fetch address (current PC).
- `if_rdata`  out  DATA_W  fetched instruction; held until the next fetch completes.
- `if_valid`  out  1  one-cycle pulse: `if_rdata` is valid.
- `mem_req`  in  1  load/store request.
- `mem_we`  in  1  1 = store.
- `mem_addr`  in  ADDR_W  load/store address.
- `mem_wdata`  in  DATA_W  store data.
- `mem_sel`  in  4  byte enables.
- `mem_rdata`  out  DATA_W  load data; held until the next MEM access completes.
- `mem_valid`  out  1  one-cycle pulse: MEM access done.
- `stallreq_id`  in  1  ID stage stall request (load-use hazard).
- `stallreq_ex`  in  1  EX stage stall request (multi-cycle op).
- `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_sel`  out  1/1/ADDR_W/DATA_W/4  registered bus command.
- `bus_ack`  in  1  bus completion, sampled on the rising edge.
- `bus_rdata`  in  DATA_W  read data, valid with `bus_ack`.
- `stall`  out  6  stage stalls: [0] PC, [1] IF/ID, [2] ID/EX, [3] EX/MEM, [4] MEM/WB, [5] WB.

## Operation
- FSM states: IDLE, IF_BUSY, MEM_BUSY. Two-bit encoding.
- IDLE:
  - If `mem_req && !mem_valid`: go to MEM_BUSY and latch the MEM command onto the bus regs.
  - Else if `if_req && !if_valid`: go to IF_BUSY and latch `if_addr` with `bus_we=0` and `bus_sel=4'hF`.
  - Else stay. MEM wins simultaneous requests.
- The `!x_valid` guard blocks re-launching the request whose completion pulse is currently high.
- IF_BUSY / MEM_BUSY:
  - `bus_req` and all bus command regs stay stable until `bus_ack` is sampled.
  - On ack: capture `bus_rdata` into `if_rdata` / `mem_rdata` (also on stores; the value is don't-care), pulse the matching valid, drop `bus_req`, return to IDLE.
- A `bus_ack` sampled while in IDLE is ignored.
- The in-flight command is never aborted by a change on `if_req`, `mem_req` or the addresses. Requesters hold requests stable until their valid pulse.
- Stall masks (combinational). `stall` is the bitwise OR of:
  - `mem_req && !mem_valid` → 6'b011111
  - `stallreq_ex` → 6'b001111
  - `stallreq_id` → 6'b000111
  - `if_req && !if_valid` → 6'b000011
  - none → 6'b000000
- `stall[5]` is always 0.

## Timing
- Reset values: state IDLE; `bus_req`=0; `bus_we`=0; `bus_addr`, `bus_wdata`, `if_rdata`, `mem_rdata` = 0; `bus_sel`=0; `if_valid` and `mem_valid` = 0.
- `stall` follows its inputs combinationally, so it is 0 whenever requests are low.
- Reset mid-transaction: `bus_req` drops asynchronously and the FSM returns to IDLE. No valid pulse is issued for the aborted access.
- Latency for an access with zero-wait ack:
  - Request seen at edge 0.
  - `bus_req` high after edge 0.
  - Ack sampled at edge 1.
  - Valid high after edge 1 for exactly one cycle.
  - Minimum 2 cycles request-to-valid; +1 per bus wait cycle.
- Back-to-back: IDLE is occupied for at least one cycle between transactions. The earliest next `bus_req` rises at the edge after the valid pulse ends.
- An IF request arriving during MEM_BUSY waits. It is served directly after (MEM → IDLE → IF_BUSY), with `stall[1:0]` held throughout.

## Structure
- Shared package `cpu_defs`:
  - state encoding constants `ST_IDLE`, `ST_IF`, `ST_MEM`.
  - stall mask constants `STALL_MEM` (6'b011111), `STALL_EX` (6'b001111), `STALL_ID` (6'b000111), `STALL_IF` (6'b000011), `STALL_NONE`.
- One sub-module is natural: `stall_gen`, the purely combinational mask OR-ing. The FSM and bus registers stay in `mem_ctrl`.

## Test plan
- Reset: assert `rst` mid-cycle with `bus_req`=1 → `bus_req`=0 immediately; no valid pulse; `stall`=0 with all requests low.
- Single fetch: `if_req`=1, `if_addr`=0x00000010, ack after 2 wait cycles with `bus_rdata`=0x3C010001:
  - `bus_addr`=0x10, `bus_we`=0.
  - `stall`=6'b000011 until `if_valid` pulses with `if_rdata`=0x3C010001.
- Simultaneous: `if_req` and store `mem_req` (`mem_addr`=0x100, `mem_wdata`=0xDEADBEEF, `mem_sel`=4'hF), zero-wait ack:
  - Store issued first, with `stall`=6'b011111.
  - Then fetch issued, with `stall`=6'b000011.
  - Exactly one `mem_valid` and one `if_valid` pulse.
- No relaunch: `mem_req` held high through `mem_valid` → no second bus transaction for the same request.
- Stall OR: `stallreq_id`=1 and `stallreq_ex`=1 with no bus activity → `stall`=6'b001111; `stallreq_id` alone → 6'b000111.
- Ack in IDLE: pulse `bus_ack` with no request → no state change, no valid pulse.
